uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Receiving end of the team's 8N1 UART link (idle-high, 1 start, 8 data LSB first, 1 stop).
//   Synchronises the asynchronous serial pin, detects the start bit, samples each bit at mid-period,
//   checks the stop bit and presents the byte with a one-cycle valid strobe.
//   Pairs with the `uart` transmitter; both use the same clocks_per_bit.
// PARAMETERS
//   clocks_per_bit  16  clock cycles per serial bit; legal range >= 4; HALF = clocks_per_bit/2 (floor)
// PORTS
//   clock          input   1  single clock; all logic on posedge
//   resetn         input   1  synchronous, active-low reset
//   pin            input   1  asynchronous serial line, idle high
//   data           output  8  last correctly framed byte; held until the next good byte
//   valid          output  1  one-cycle pulse: data updated this cycle
//   framing_error  output  1  one-cycle pulse: stop bit sampled low
//   busy           output  1  high in any state other than IDLE
// BEHAVIOUR
//   Reset: one clock; interface is synchronous, active-low reset `resetn`.
//   - resetn low at a posedge: state=IDLE, both sync flops=1, data=0, valid=0, framing_error=0, busy=0,
//     counters and shift register=0. Reset mid-frame abandons the frame; no valid/error pulse.
//   Synchroniser: two flops, pin -> s1 -> s2; FSM uses s2 only.
//   Counter `clocks` width $clog2(clocks_per_bit)+1; `bit_index` 0..7.
//   FSM:
//   - IDLE: s2==0 -> START, clocks=0. Else stay.
//   - START: clocks counts up; when clocks==HALF-1: if s2==0 -> DATA, clocks=0, bit_index=0;
//     if s2==1 -> IDLE (glitch rejected, no pulse).
//   - DATA: when clocks==clocks_per_bit-1: shift[bit_index]=s2, clocks=0;
//     bit_index==7 -> STOP, else bit_index+1. Otherwise clocks+1.
//   - STOP: when clocks==clocks_per_bit-1: s2==1 -> data=shift, valid=1, -> IDLE;
//     s2==0 -> framing_error=1, data unchanged, -> BREAK.
//   - BREAK: wait for s2==1, then -> IDLE (prevents a low line re-triggering START).
//   valid and framing_error: high exactly one cycle, never together; 0 in all other cycles.
//   Timing (edge 0 = first posedge capturing pin=0 into s1): FSM enters START after edge 2;
//   start checked at edge 2+HALF; data bit k sampled at edge 2+HALF+(k+1)*clocks_per_bit;
//   stop at edge 2+HALF+9*clocks_per_bit; valid high in the cycle after that edge.
//   Back-to-back frames: return to IDLE at stop sample, so a start bit immediately after the
//   stop bit is accepted (stop bit tolerance: frame may be short by up to HALF-1 cycles).
//   No consumer handshake: a byte not read before the next valid is overwritten.
// TESTING (clocks_per_bit=16, HALF=8)
//   1. Drive 0xA5 as 8N1 -> valid single pulse in cycle after edge 2+8+144=154, data=0xA5, busy low after.
//   2. pin low for 4 cycles then high -> no valid, no framing_error, busy drops after start check.
//   3. 0x3C with stop bit low, line held low 40 cycles, then 0x5A -> framing_error once, data
//      unchanged; BREAK until line high; then valid with data=0x5A.
//   4. 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses, data 0x00 then 0xFF.
//   5. resetn low for 1 cycle mid bit 4 of 0x81 -> all outputs 0 next cycle, no pulse;
//      following 0x7E received correctly.
//   6. Loopback from `uart` (clocks_per_bit=16) sending all 256 values -> 256 valids, data matches in order, zero errors.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop pin synchroniser, mid-bit sampling FSM, stop-bit check,
// registered data with one-cycle valid / framing_error strobes.
module uart_rx #(
    parameter int unsigned clocks_per_bit = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pin,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(clocks_per_bit) + 1;
    localparam int unsigned Half = clocks_per_bit / 2;
    localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(clocks_per_bit - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CntW-1:0] clocks_q, clocks_d;
    logic [2:0]      bit_index_q, bit_index_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            // Sync flops reset to the idle line level so reset never looks like a start bit.
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StIdle;
            clocks_q    <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sync1_q     <= pin;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            clocks_q    <= clocks_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clocks_d    = clocks_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (!sync2_q) begin
                    state_d  = StStart;
                    clocks_d = '0;
                end
            end

            StStart: begin
                // Re-check the line half a bit in; a high line here was only a glitch.
                if (clocks_q == HalfLast) begin
                    clocks_d = '0;
                    if (!sync2_q) begin
                        state_d     = StData;
                        bit_index_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    clocks_d = clocks_q + CntOne;
                end
            end

            StData: begin
                if (clocks_q == BitLast) begin
                    clocks_d               = '0;
                    shift_d[bit_index_q]   = sync2_q;
                    if (bit_index_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clocks_d = clocks_q + CntOne;
                end
            end

            StStop: begin
                if (clocks_q == BitLast) begin
                    clocks_d = '0;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    clocks_d = clocks_q + CntOne;
                end
            end

            StBreak: begin
                // Hold off until the line returns high so a stuck-low line cannot re-trigger.
                if (sync2_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: the whole line waveform is built up front, and expected strobes, busy and
// data are placed on the same timeline from the frame timing rules, then checked every cycle.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int N    = 65536;
    localparam int LAT  = 2 + HALF + 9 * CPB;  // start edge to stop-sample edge

    logic       clock = 1'b0;
    logic       resetn;
    logic       pin;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;

    uart_rx #(.clocks_per_bit(CPB)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pin           (pin),
        .data          (data),
        .valid         (valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Index t = value captured at / expected after posedge number t.
    bit         line_a  [N];
    bit         rstn_a  [N];
    bit         ev_valid[N];
    bit         ev_ferr [N];
    bit         ev_busy [N];
    bit         ev_set  [N];
    bit         ev_rst  [N];
    logic [7:0] ev_byte [N];
    logic [7:0] exp_data[N];

    int tp = 0;
    int n_assert = 0;
    int n_fail = 0;
    int vt[$];
    logic [7:0] vd[$];
    int ft[$];

    task automatic put(input bit v, input bit r);
        if (tp >= N) begin
            $display("FAIL stimulus_overflow: length %0d required below %0d", tp, N);
            $fatal(1);
        end
        line_a[tp] = v;
        rstn_a[tp] = r;
        tp++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b1, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            ev_rst[tp] = 1'b1;
            put(1'b1, 1'b0);
        end
    endtask

    task automatic busy_range(input int a, input int b);
        for (int t = a; t <= b; t++) if (t < N) ev_busy[t] = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input int short_k,
                        input int low_extra);
        int e0, ts, h;
        e0 = tp;
        ts = e0 + LAT;
        for (int i = 0; i < CPB; i++) put(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) for (int i = 0; i < CPB; i++) put(b[k], 1'b1);
        if (stop_ok) begin
            for (int i = 0; i < CPB - short_k; i++) put(1'b1, 1'b1);
            busy_range(e0 + 2, ts - 1);
            ev_valid[ts] = 1'b1;
            ev_set[ts]   = 1'b1;
            ev_byte[ts]  = b;
        end else begin
            for (int i = 0; i < CPB + low_extra; i++) put(1'b0, 1'b1);
            h = tp;  // first edge capturing the line high again
            put(1'b1, 1'b1);
            busy_range(e0 + 2, h + 1);
            ev_ferr[ts] = 1'b1;
        end
    endtask

    task automatic glitch(input int len);
        int g;
        g = tp;
        for (int i = 0; i < len; i++) put(1'b0, 1'b1);
        busy_range(g + 2, g + 1 + HALF);
        idle(HALF + 2);
    endtask

    task automatic abort_frame(input logic [7:0] b, input int r_off);
        int e0, bi;
        bit v;
        e0 = tp;
        for (int i = 0; i < r_off; i++) begin
            bi = i / CPB;
            v = (bi == 0) ? 1'b0 : ((bi <= 8) ? b[bi-1] : 1'b1);
            put(v, 1'b1);
        end
        ev_rst[tp] = 1'b1;
        put(1'b1, 1'b0);
        busy_range(e0 + 2, e0 + r_off - 1);
    endtask

    task automatic chk(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s at cycle %0d: got %0h required %0h", name, t, act, req);
        end
    endtask

    task automatic nth_valid(input int from, input int n, output int t, output logic [7:0] d);
        int c;
        c = 0;
        t = -1;
        d = 'x;
        foreach (vt[i]) begin
            if (vt[i] >= from) begin
                if (c == n) begin
                    t = vt[i];
                    d = vd[i];
                    break;
                end
                c++;
            end
        end
    endtask

    int e0_1, e0_3, e0_3b, e0_4, e0_5, e0_5b, e0_6, e6_end, total;
    int kind, t0, t1, cnt_v, cnt_f, model_v, model_f;
    logic [7:0] d0, d1, dm;

    initial begin
        do_reset(3);
        idle(10);
        e0_1 = tp;  send(8'hA5, 1'b1, 0, 0);  idle(20);
        glitch(4);  idle(10);
        e0_3 = tp;  send(8'h3C, 1'b0, 0, 40); idle(20);
        e0_3b = tp; send(8'h5A, 1'b1, 0, 0);  idle(20);
        e0_4 = tp;  send(8'h00, 1'b1, 0, 0);  send(8'hFF, 1'b1, 0, 0); idle(20);
        e0_5 = tp;  abort_frame(8'h81, 5 * CPB + 5); idle(20);
        e0_5b = tp; send(8'h7E, 1'b1, 0, 0);  idle(20);
        e0_6 = tp;
        for (int v = 0; v < 256; v++) send(8'(v), 1'b1, 0, 0);
        idle(20);
        e6_end = tp;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send(8'($urandom), 1'b1, $urandom_range(0, HALF - 1), 0);
                idle($urandom_range(0, 5));
            end else if (kind <= 7) begin
                glitch($urandom_range(1, HALF));
                idle($urandom_range(0, 3));
            end else if (kind == 8) begin
                send(8'($urandom), 1'b0, 0, $urandom_range(0, 30));
                idle($urandom_range(0, 5));
            end else begin
                send(8'($urandom), 1'b1, 0, 0);
                idle(1);
            end
        end
        idle(30);
        total = tp;

        dm = 8'h00;
        model_v = 0;
        model_f = 0;
        for (int t = 0; t < total; t++) begin
            if (ev_rst[t]) dm = 8'h00;
            else if (ev_set[t]) dm = ev_byte[t];
            exp_data[t] = dm;
            model_v += int'(ev_valid[t]);
            model_f += int'(ev_ferr[t]);
        end

        pin = line_a[0];
        resetn = rstn_a[0];
        fork
            begin
                for (int t = 0; t < total - 1; t++) begin
                    @(posedge clock);
                    #1;
                    pin = line_a[t+1];
                    resetn = rstn_a[t+1];
                end
            end
            begin
                for (int t = 0; t < total; t++) begin
                    @(posedge clock);
                    @(negedge clock);
                    chk("valid", t, 32'(valid), 32'(ev_valid[t]));
                    chk("framing_error", t, 32'(framing_error), 32'(ev_ferr[t]));
                    chk("busy", t, 32'(busy), 32'(ev_busy[t]));
                    chk("data", t, 32'(data), 32'(exp_data[t]));
                    if (valid === 1'b1) begin
                        vt.push_back(t);
                        vd.push_back(data);
                    end
                    if (framing_error === 1'b1) ft.push_back(t);
                end
            end
        join

        // Hand-computed anchors for the model itself.
        nth_valid(e0_1, 0, t0, d0);
        chk("t1_latency", t0, t0 - e0_1, 154);
        chk("t1_data", t0, 32'(d0), 32'h A5);

        t1 = -1;
        foreach (ft[i]) if (ft[i] >= e0_3 && t1 < 0) t1 = ft[i];
        chk("t3_ferr_latency", t1, t1 - e0_3, 154);
        nth_valid(e0_3, 0, t0, d0);
        chk("t3_next_valid_time", t0, t0 - e0_3b, 154);
        chk("t3_next_data", t0, 32'(d0), 32'h5A);

        nth_valid(e0_4, 0, t0, d0);
        nth_valid(e0_4, 1, t1, d1);
        chk("t4_first_data", t0, 32'(d0), 32'h00);
        chk("t4_second_data", t1, 32'(d1), 32'hFF);
        chk("t4_spacing", t1, t1 - t0, 160);

        nth_valid(e0_5, 0, t0, d0);
        chk("t5_valid_time", t0, t0 - e0_5b, 154);
        chk("t5_data", t0, 32'(d0), 32'h7E);

        cnt_v = 0;
        cnt_f = 0;
        foreach (vt[i]) if (vt[i] >= e0_6 && vt[i] < e6_end) cnt_v++;
        foreach (ft[i]) if (ft[i] >= e0_6 && ft[i] < e6_end) cnt_f++;
        chk("t6_valid_count", e6_end, cnt_v, 256);
        chk("t6_error_count", e6_end, cnt_f, 0);
        chk("total_valids", total, vt.size(), model_v);
        chk("total_errors", total, ft.size(), model_f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
